fsm_com: RTL and testbench
==========================

# fsm_com

`fsm_com` is a Moore-style command controller. It accepts a start request (`N`), a 2-bit mode code (`T`) and right/left step commands (`D`/`I`). It maintains a 4-bit position shown on `LCD`, drives the mode onto `Gen`, and reports status on a green LED (`LV`) and a red LED (`LR`). It sits between the front-panel inputs and the display/LED drivers of the state-machine project.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 64: number of consecutive RUN cycles without a step command before RUN returns to IDLE.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `D`  input  1  step right (increment position).
- `I`  input  1  step left (decrement position).
- `N`  input  1  start/stop request.
- `T`  input  2  mode code; 2'b00 is invalid.
- `LCD`  output  4  display value: the current position, or 4'hF in ERROR.
- `Gen`  output  2  generator code: the latched mode in RUN, 2'b11 in ERROR, otherwise 2'b00.
- `LV`  output  1  green LED; 1 only in RUN.
- `LR`  output  1  red LED; 1 in IDLE and in ERROR.

One clock; reset is asynchronous and active-low.

## Operation
Internal registers:
- `state` (2 bits): IDLE=00, ARM=01, RUN=10, ERROR=11.
- `pos` (4 bits).
- `mode` (2 bits).
- `tmo`: idle counter, `$clog2(IDLE_TIMEOUT)+1` bits.

Reset (`reset`=0) forces state=IDLE, pos=0, mode=0, tmo=0, independent of `clk`.

State behaviour and transitions (evaluated each rising edge):
- IDLE:
  - N=1 and T≠00: mode←T, pos←0, go to ARM.
  - N=1 and T=00: go to ERROR.
  - Otherwise stay.
  - D and I are ignored.
- ARM:
  - Wait for N to be released. N=0 → RUN, tmo←0.
  - Changes on T are ignored; mode stays latched.
  - D=I=1 while armed → ERROR.
- RUN:
  - N=1 → IDLE (stop). This has the highest priority in RUN.
  - D=1 and I=1 → ERROR.
  - D=1 only: pos←pos+mode (mod 16), tmo←0.
  - I=1 only: pos←pos−mode (mod 16), tmo←0.
  - Neither: tmo←tmo+1. When tmo reaches IDLE_TIMEOUT−1 → IDLE.
  - Steps are level-based: one step per cycle while held.
- ERROR:
  - Leaves only when D=0, I=0, N=0 and T=00 in the same cycle → IDLE, pos←0.

Output decode (purely from registered state, pos and mode):
- IDLE: LCD=pos, Gen=00, LV=0, LR=1.
- ARM: LCD=pos, Gen=00, LV=0, LR=0.
- RUN: LCD=pos, Gen=mode, LV=1, LR=0.
- ERROR: LCD=4'hF, Gen=11, LV=0, LR=1.

Arithmetic and boundary rules:
- Position arithmetic is 4-bit wrap-around with no saturation: 15+1=0, 0−1=15, 14+3=1.
- Stopping from RUN to IDLE keeps pos visible on LCD; pos is cleared on the next start.
- The timeout exit leaves pos unchanged.

## Timing
- Outputs reflect the state and register values loaded at the most recent rising edge. There is no combinational path from inputs to outputs.
- Input-to-output latency is 1 clock.
- Start sequence: the N rising edge is sampled at edge k and the block enters ARM. N=0 is sampled at edge m>k and the block enters RUN; LV=1 after edge m.
- A single-cycle N pulse gives IDLE→ARM at edge k and ARM→RUN at edge k+1.
- N held continuously in RUN causes RUN→IDLE. It does not re-arm until N is released and asserted again: IDLE accepts a start only on an N low-to-high transition, so an N-previous register is required.
- Reset asserted mid-operation takes effect immediately, without waiting for an edge. Outputs go to the IDLE values: LCD=0, Gen=00, LV=0, LR=1.
- Inputs are synchronous to `clk`; no internal synchronisers are provided.

## Test plan
- Reset: assert reset=0 → LCD=0000, Gen=00, LV=0, LR=1 immediately. Release reset with all inputs 0 for 10 cycles → outputs unchanged.
- Start and step:
  - T=10, N=1 for 3 cycles, then N=0 → RUN: LV=1, LR=0, Gen=10.
  - D=1 for 3 cycles → LCD steps 2, 4, 6.
  - I=1 for 1 cycle → LCD=4.
- Wrap-around: mode 11 from pos 0; I=1 for 1 cycle → LCD=1101. Then D=1 for 2 cycles → LCD=0000, then 0011.
- Error entry and exit:
  - In RUN, D=I=1 → LCD=1111, Gen=11, LR=1, LV=0.
  - Hold T=01 → stays in ERROR.
  - All inputs 0 → IDLE: LCD=0, LR=1.
- Invalid start: N=1 with T=00 in IDLE → ERROR on the next edge.
- Stop and timeout:
  - In RUN, N=1 → IDLE on the next edge with LCD holding the last pos.
  - Restart, then no D/I for IDLE_TIMEOUT cycles → IDLE, LV=0, LR=1.

Source files
------------

// File: rtl/fsm_com.sv
// fsm_com: Moore command controller for the front panel.
//   A start request (N rising edge) latches the mode code T and arms the block.
//   Releasing N enters RUN, where D/I step a 4-bit position by +/-mode.
//   RUN falls back to IDLE on N (stop) or after IDLE_TIMEOUT quiet cycles.
//   Conflicting D and I, or a start with T=00, enters ERROR.
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous, active-low reset
//   D, I        step right / step left (level, one step per cycle)
//   N           start/stop request
//   T[1:0]      mode code (00 is invalid)
//   LCD[3:0]    position, or 4'hF in ERROR
//   Gen[1:0]    latched mode in RUN, 11 in ERROR, else 00
//   LV, LR      green LED (RUN) / red LED (IDLE, ERROR)
module fsm_com #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D,
  input  logic       I,
  input  logic       N,
  input  logic [1:0] T,
  output logic [3:0] LCD,
  output logic [1:0] Gen,
  output logic       LV,
  output logic       LR
);

  localparam int TMO_W = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARM   = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [1:0]       mode_q, mode_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             n_prev_q, n_prev_d;

  logic n_rise;
  assign n_rise = N & ~n_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pos_q    <= 4'd0;
      mode_q   <= 2'd0;
      tmo_q    <= '0;
      n_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      mode_q   <= mode_d;
      tmo_q    <= tmo_d;
      n_prev_q <= n_prev_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    mode_d   = mode_q;
    tmo_d    = tmo_q;
    n_prev_d = N;
    unique case (state_q)
      S_IDLE: begin
        // Only a fresh N edge starts, so N held through a stop cannot re-arm.
        if (n_rise) begin
          if (T != 2'b00) begin
            mode_d  = T;
            pos_d   = 4'd0;
            state_d = S_ARM;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ARM: begin
        // Conflicting step commands take precedence over the N release.
        if (D && I) begin
          state_d = S_ERROR;
        end else if (!N) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (N) begin
          state_d = S_IDLE;
        end else if (D && I) begin
          state_d = S_ERROR;
        end else if (D) begin
          pos_d = pos_q + {2'b00, mode_q};
          tmo_d = '0;
        end else if (I) begin
          pos_d = pos_q - {2'b00, mode_q};
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ERROR: begin
        if (!D && !I && !N && T == 2'b00) begin
          pos_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode uses registered values only.
  always_comb begin
    LCD = pos_q;
    Gen = 2'b00;
    LV  = 1'b0;
    LR  = 1'b0;
    unique case (state_q)
      S_IDLE:  LR = 1'b1;
      S_ARM:   ;
      S_RUN: begin
        Gen = mode_q;
        LV  = 1'b1;
      end
      S_ERROR: begin
        LCD = 4'hF;
        Gen = 2'b11;
        LR  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_com.sv
// Bench for fsm_com: directed steps following the front-panel scenarios, then
// random stimulus, all checked against a flag-based behavioural model.
module tb_fsm_com;
  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D = 1'b0, I = 1'b0, N = 1'b0;
  logic [1:0] T = 2'b00;
  logic [3:0] LCD;
  logic [1:0] Gen;
  logic       LV, LR;

  int total = 0;
  int bad = 0;

  fsm_com #(.IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .D(D), .I(I), .N(N), .T(T),
    .LCD(LCD), .Gen(Gen), .LV(LV), .LR(LR)
  );

  always #5 clk = ~clk;

  // Model: activity flags instead of an encoded state.
  bit   m_arm, m_run, m_err, m_nprev;
  int   m_pos, m_mode, m_quiet;

  task automatic model_reset();
    m_arm = 0; m_run = 0; m_err = 0; m_nprev = 0;
    m_pos = 0; m_mode = 0; m_quiet = 0;
  endtask

  task automatic model_edge(input bit d, input bit i, input bit n, input int t);
    if (m_err) begin
      if (!d && !i && !n && t == 0) begin m_err = 0; m_pos = 0; end
    end else if (m_arm) begin
      if (d && i) begin m_arm = 0; m_err = 1; end
      else if (!n) begin m_arm = 0; m_run = 1; m_quiet = 0; end
    end else if (m_run) begin
      if (n) m_run = 0;
      else if (d && i) begin m_run = 0; m_err = 1; end
      else if (d) begin m_pos = (m_pos + m_mode) % 16; m_quiet = 0; end
      else if (i) begin m_pos = (m_pos + 16 - m_mode) % 16; m_quiet = 0; end
      else begin
        m_quiet++;
        if (m_quiet >= TO) m_run = 0;
      end
    end else begin
      if (n && !m_nprev) begin
        if (t != 0) begin m_mode = t; m_pos = 0; m_arm = 1; end
        else m_err = 1;
      end
    end
    m_nprev = n;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_lcd, e_gen, e_lv, e_lr;
    e_lcd = m_err ? 8'hF : 8'(m_pos);
    e_gen = m_err ? 8'h3 : (m_run ? 8'(m_mode) : 8'h0);
    e_lv  = m_run ? 8'h1 : 8'h0;
    e_lr  = (m_err || (!m_arm && !m_run)) ? 8'h1 : 8'h0;
    chk({tag, ".LCD"}, {4'h0, LCD}, e_lcd);
    chk({tag, ".Gen"}, {6'h0, Gen}, e_gen);
    chk({tag, ".LV"},  {7'h0, LV},  e_lv);
    chk({tag, ".LR"},  {7'h0, LR},  e_lr);
  endtask

  task automatic step(input bit d, input bit i, input bit n, input int t, input string tag);
    D = d; I = i; N = n; T = 2'(t);
    model_edge(d, i, n, t);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #2 check_all("reset_async");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, "idle_hold");

    // Start with mode 2, N held for three cycles.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 2, "arm_hold");
    step(0, 0, 0, 2, "run_enter");
    for (int k = 0; k < 3; k++) step(1, 0, 0, 2, "step_right");
    step(0, 1, 0, 2, "step_left");

    // Stop keeps pos; N held does not re-arm.
    step(0, 0, 1, 0, "stop");
    step(0, 0, 1, 3, "no_rearm");
    step(0, 0, 0, 3, "idle_release");

    // Mode 3 wrap-around.
    step(0, 0, 1, 3, "arm_m3");
    step(0, 0, 0, 1, "run_m3");
    step(0, 1, 0, 0, "wrap_left");
    step(1, 0, 0, 0, "wrap_right0");
    step(1, 0, 0, 0, "wrap_right3");

    // Error entry, hold and exit.
    step(1, 1, 0, 0, "err_enter");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, "err_hold");
    step(0, 0, 0, 0, "err_exit");

    // Invalid start.
    step(0, 0, 1, 0, "bad_start");
    step(0, 0, 0, 0, "bad_exit");

    // Timeout from RUN.
    step(0, 0, 1, 1, "tmo_arm");
    step(0, 0, 0, 1, "tmo_run");
    step(1, 0, 0, 1, "tmo_step");
    for (int k = 0; k < TO; k++) step(0, 0, 0, 1, "tmo_quiet");
    step(0, 0, 0, 1, "tmo_after");

    // Conflicting steps while armed.
    step(0, 0, 1, 2, "arm2");
    step(1, 1, 1, 2, "arm_conflict");
    step(0, 0, 0, 0, "arm_err_exit");

    // Reset mid-operation, between edges.
    step(0, 0, 1, 3, "mid_arm");
    step(0, 0, 0, 3, "mid_run");
    step(1, 0, 0, 3, "mid_step");
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("reset_mid");
    reset = 1'b1;
    step(0, 0, 0, 0, "post_reset");

    // Random stimulus.
    for (int k = 0; k < 600; k++) begin
      bit rd, ri, rn;
      int rt;
      rd = ($urandom_range(0, 2) == 0);
      ri = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 5) == 0);
      rt = $urandom_range(0, 3);
      // Occasionally force an error-exit pattern so ERROR does not stick.
      if ($urandom_range(0, 7) == 0) begin rd = 0; ri = 0; rn = 0; rt = 0; end
      step(rd, ri, rn, rt, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
